// File: rtl/simon_pkg.sv
// Shared types and defaults for the Simon game button front end.
package simon_pkg;

    localparam int N_BTN_DEFAULT = 4;
    localparam int BTN_IDX_W     = $clog2(N_BTN_DEFAULT);

    typedef logic [BTN_IDX_W-1:0] btn_idx_t;

endpackage

// File: rtl/button_debounce_chan.sv
// One debounce channel: stability counter plus accepted level.
// rise/fall are the combinational "level flips on this edge" strobes.
module debounce_chan
    import simon_pkg::*;
#(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             differ, accept;

    always_comb begin
        differ  = raw ^ level_q;
        accept  = differ && (cnt_q == CNT_LAST);
        cnt_d   = '0;
        level_d = level_q;
        // Any matching sample (bounce) drops the count back to zero.
        if (differ && !accept) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (accept) begin
            level_d = raw;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
    assign rise  = accept & raw;
    assign fall  = accept & ~raw;

endmodule

// File: rtl/button_debounce.sv
// Per-button debounce with press pulses and a lowest-index press event.
// Optional release pulses are built when BTN_RELEASE_EVT_EN is defined.
module button_debounce
    import simon_pkg::*;
#(
    parameter  int N_BTN     = N_BTN_DEFAULT,
    parameter  int DB_CYCLES = 500000,
    localparam int IDX_W     = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] raw_btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic             any_down,
    output logic             press_valid,
    output logic [IDX_W-1:0] press_idx
`ifdef BTN_RELEASE_EVT_EN
    ,
    output logic [N_BTN-1:0] btn_release
`endif
);

    logic [N_BTN-1:0] level_w, rise_w;
`ifdef BTN_RELEASE_EVT_EN
    logic [N_BTN-1:0] fall_w;
    logic [N_BTN-1:0] btn_release_q, btn_release_d;
`else
    logic [N_BTN-1:0] fall_unused;
`endif

    logic [N_BTN-1:0] btn_press_q, btn_press_d;
    logic             press_valid_q, press_valid_d;
    logic [IDX_W-1:0] press_idx_q, press_idx_d;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        debounce_chan #(
            .DB_CYCLES(DB_CYCLES)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_btn[g]),
            .level (level_w[g]),
            .rise  (rise_w[g]),
`ifdef BTN_RELEASE_EVT_EN
            .fall  (fall_w[g])
`else
            .fall  (fall_unused[g])
`endif
        );
    end

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_BTN-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Strobes are registered on the same edge the level flips, so the
    // pulses coincide with the first cycle the new level is visible.
    always_comb begin
        btn_press_d   = rise_w;
        press_valid_d = |rise_w;
        press_idx_d   = press_valid_d ? lowest_set(rise_w) : press_idx_q;
`ifdef BTN_RELEASE_EVT_EN
        btn_release_d = fall_w;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_press_q   <= '0;
            press_valid_q <= 1'b0;
            press_idx_q   <= '0;
`ifdef BTN_RELEASE_EVT_EN
            btn_release_q <= '0;
`endif
        end else begin
            btn_press_q   <= btn_press_d;
            press_valid_q <= press_valid_d;
            press_idx_q   <= press_idx_d;
`ifdef BTN_RELEASE_EVT_EN
            btn_release_q <= btn_release_d;
`endif
        end
    end

    assign btn_level   = level_w;
    assign btn_press   = btn_press_q;
    assign press_valid = press_valid_q;
    assign press_idx   = press_idx_q;
    assign any_down    = |level_w;
`ifdef BTN_RELEASE_EVT_EN
    assign btn_release = btn_release_q;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce (DB_CYCLES = 4): directed cases plus random
// bouncing, checked every cycle against a sample-history model.
module tb_button_debounce;
    import simon_pkg::*;

    localparam int N  = 4;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] raw_btn = 4'b1111;
    logic [N-1:0] btn_level, btn_press;
    logic         any_down, press_valid;
    logic [1:0]   press_idx;
`ifdef BTN_RELEASE_EVT_EN
    logic [N-1:0] btn_release;
`endif

    int total = 0;
    int bad   = 0;

    button_debounce #(
        .N_BTN    (N),
        .DB_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_btn    (raw_btn),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .any_down   (any_down),
        .press_valid(press_valid),
        .press_idx  (press_idx)
`ifdef BTN_RELEASE_EVT_EN
        ,
        .btn_release(btn_release)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a button's level flips once the last DB post-reset samples
    // all disagree with the currently accepted level.
    logic [DB-1:0] hist [N];
    int            seen [N];
    logic [N-1:0]  exp_level, exp_press, exp_rel;
    logic          exp_pv;
    btn_idx_t      exp_idx;
    bit            model_ok = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                hist[i] = '0;
                seen[i] = 0;
            end
            exp_level = '0;
            exp_press = '0;
            exp_rel   = '0;
            exp_pv    = 1'b0;
            exp_idx   = '0;
            model_ok  = 1;
        end else begin
            exp_press = '0;
            exp_rel   = '0;
            for (int i = 0; i < N; i++) begin
                hist[i] = {hist[i][DB-2:0], raw_btn[i]};
                if (seen[i] < DB) seen[i]++;
                if (seen[i] >= DB && hist[i] == {DB{~exp_level[i]}}) begin
                    exp_level[i] = ~exp_level[i];
                    if (exp_level[i]) exp_press[i] = 1'b1;
                    else              exp_rel[i]   = 1'b1;
                end
            end
            exp_pv = |exp_press;
            if (exp_pv) begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (exp_press[i]) exp_idx = btn_idx_t'(i);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("level", 32'(btn_level), 32'(exp_level));
            check("press", 32'(btn_press), 32'(exp_press));
            check("any_down", 32'(any_down), 32'(|exp_level));
            check("press_valid", 32'(press_valid), 32'(exp_pv));
            check("press_idx", 32'(press_idx), 32'(exp_idx));
`ifdef BTN_RELEASE_EVT_EN
            check("release", 32'(btn_release), 32'(exp_rel));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int hold [N];

    initial begin
        // 1: held through reset, accepted DB edges after release
        step(3);
        check("t1_rst_level", 32'(btn_level), 32'h0);
        check("t1_rst_press", 32'(btn_press), 32'h0);
        check("t1_rst_pv", 32'(press_valid), 32'h0);
        reset = 1'b0;
        step(3);
        check("t1_level_early", 32'(btn_level), 32'h0);
        step(1);
        check("t1_level", 32'(btn_level), 32'hf);
        check("t1_press", 32'(btn_press), 32'hf);
        check("t1_idx", 32'(press_idx), 32'h0);
        check("t1_model_level", 32'(exp_level), 32'hf);

        raw_btn = 4'b0000;
        step(6);
        check("t2_pre_level", 32'(btn_level), 32'h0);

        // 2: bounce never survives long enough
        for (int r = 0; r < 5; r++) begin
            raw_btn[2] = 1'b1;
            step(3);
            raw_btn[2] = 1'b0;
            step(1);
        end
        check("t2_level", 32'(btn_level), 32'h0);
        check("t2_any_down", 32'(any_down), 32'h0);

        // 3: clean press held 20 cycles
        raw_btn[2] = 1'b1;
        step(3);
        check("t3_press_early", 32'(btn_press), 32'h0);
        step(1);
        check("t3_level", 32'(btn_level), 32'h4);
        check("t3_press", 32'(btn_press), 32'h4);
        check("t3_pv", 32'(press_valid), 32'h1);
        check("t3_idx", 32'(press_idx), 32'h2);
        check("t3_model_press", 32'(exp_press), 32'h4);
        step(1);
        check("t3_press_once", 32'(btn_press), 32'h0);
        check("t3_pv_once", 32'(press_valid), 32'h0);
        check("t3_idx_held", 32'(press_idx), 32'h2);
        step(15);
        check("t3_any_down", 32'(any_down), 32'h1);

        // 6: release
        raw_btn[2] = 1'b0;
        step(3);
        check("t6_level_early", 32'(btn_level), 32'h4);
        step(1);
        check("t6_level", 32'(btn_level), 32'h0);
        check("t6_pv", 32'(press_valid), 32'h0);
`ifdef BTN_RELEASE_EVT_EN
        check("t6_release", 32'(btn_release), 32'h4);
`endif
        step(2);

        // 4: simultaneous presses, lowest index reported
        raw_btn = 4'b1010;
        step(3);
        check("t4_press_early", 32'(btn_press), 32'h0);
        step(1);
        check("t4_press", 32'(btn_press), 32'ha);
        check("t4_pv", 32'(press_valid), 32'h1);
        check("t4_idx", 32'(press_idx), 32'h1);
        step(1);
        check("t4_pv_once", 32'(press_valid), 32'h0);
        raw_btn = 4'b0000;
        step(6);

        // 5: partial count discarded by reset
        raw_btn = 4'b0001;
        step(3);
        check("t5_press_pre", 32'(btn_press), 32'h0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("t5_level_rst", 32'(btn_level), 32'h0);
        step(3);
        check("t5_press_early", 32'(btn_press), 32'h0);
        step(1);
        check("t5_press", 32'(btn_press), 32'h1);
        check("t5_idx", 32'(press_idx), 32'h0);

        // Random bouncing with occasional reset
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    raw_btn[i] = 1'($urandom_range(0, 1));
                    hold[i]    = $urandom_range(1, 7);
                end else begin
                    hold[i]--;
                end
            end
            reset = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
